// File: rtl/load_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// load_store_unit : RISC-V byte/half/word load-store engine with wait states,
// split misaligned accesses and bus timeout.                        Rev 1.0
// ----------------------------------------------------------------------------
module load_store_unit #(
   parameter int ADDR_WIDTH     = 16,
   parameter bit MISALIGNED_EN  = 1'b1,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_address,
   input  logic [31:0]           req_data,
   output logic                  resp_valid,
   output logic [31:0]           resp_data,
   output logic                  resp_error,
   output logic                  bus_enable,
   output logic                  bus_write_enable,
   output logic [ADDR_WIDTH-1:0] bus_address,
   output logic [31:0]           bus_write_data,
   output logic [3:0]            bus_write_mask,
   input  logic [31:0]           bus_read_data,
   input  logic                  bus_data_ready
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ACCESS_0 = 3'd1;
   localparam logic [2:0] S_GAP      = 3'd2;
   localparam logic [2:0] S_ACCESS_1 = 3'd3;
   localparam logic [2:0] S_RESPOND  = 3'd4;

   localparam int              TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [2:0]            state;
   logic                  wr;
   logic [1:0]            size;
   logic                  uns;
   logic [ADDR_WIDTH-1:0] addr;
   logic [31:0]           data;
   logic                  split;
   logic                  err;
   logic [TW-1:0]         timer;
   logic [31:0]           word0;
   logic [31:0]           word1;

   logic       req_misaligned;
   logic       req_reject;
   logic       timeout;
   logic       in_access;
   logic [1:0] off;
   logic [7:0] lane_base;
   logic [7:0] lane_pair;
   logic [31:0] rep;
   logic [31:0] wdata;
   logic [31:0] shifted;
   logic [31:0] load_ext;
   logic [ADDR_WIDTH-1:0] word_addr;

   assign req_misaligned = ((req_size == 2'd1) && (req_address[1:0] == 2'd3)) ||
                           ((req_size == 2'd2) && (req_address[1:0] != 2'd0));
   assign req_reject     = (req_size == 2'd3) || (req_misaligned && (MISALIGNED_EN == 1'b0));
   assign timeout        = (TIMEOUT_CYCLES != 0) && (timer == T_LAST);

   assign off       = addr[1:0];
   assign word_addr = {addr[ADDR_WIDTH-1:2], 2'b00};

   // Lane enables across the word pair: low nibble for half 0, high nibble for half 1
   always_comb begin
      case (size)
         2'd0:    lane_base = 8'h01;
         2'd1:    lane_base = 8'h03;
         default: lane_base = 8'h0f;
      endcase
      lane_pair = lane_base << off;
   end

   // Replicated data rotated within one word serves both halves of a split store
   always_comb begin
      case (size)
         2'd0:    rep = {4{data[7:0]}};
         2'd1:    rep = {2{data[15:0]}};
         default: rep = data;
      endcase
      case (off)
         2'd0:    wdata = rep;
         2'd1:    wdata = {rep[23:0], rep[31:24]};
         2'd2:    wdata = {rep[15:0], rep[31:16]};
         default: wdata = {rep[7:0],  rep[31:8]};
      endcase
   end

   always_comb begin
      shifted = 32'({word1, word0} >> {off, 3'b000});
      case (size)
         2'd0:    load_ext = uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}},  shifted[7:0]};
         2'd1:    load_ext = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         default: load_ext = shifted;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         wr    <= 1'b0;
         size  <= 2'd0;
         uns   <= 1'b0;
         addr  <= '0;
         data  <= 32'h0;
         split <= 1'b0;
         err   <= 1'b0;
         timer <= '0;
         word0 <= 32'h0;
         word1 <= 32'h0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  wr    <= req_write;
                  size  <= req_size;
                  uns   <= req_unsigned;
                  addr  <= req_address;
                  data  <= req_data;
                  split <= req_misaligned;
                  err   <= req_reject;
                  timer <= '0;
                  word0 <= 32'h0;
                  word1 <= 32'h0;
                  state <= req_reject ? S_RESPOND : S_ACCESS_0;
               end
            end
            S_ACCESS_0: begin
               if (bus_data_ready) begin
                  word0 <= bus_read_data;
                  timer <= '0;
                  state <= split ? S_GAP : S_RESPOND;
               end else if (timeout) begin
                  err   <= 1'b1;
                  state <= S_RESPOND;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_GAP: state <= S_ACCESS_1;
            S_ACCESS_1: begin
               if (bus_data_ready) begin
                  word1 <= bus_read_data;
                  state <= S_RESPOND;
               end else if (timeout) begin
                  err   <= 1'b1;
                  state <= S_RESPOND;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_RESPOND: state <= S_IDLE;
            default:   state <= S_IDLE;
         endcase
      end
   end

   assign in_access        = (state == S_ACCESS_0) || (state == S_ACCESS_1);
   assign req_ready        = (state == S_IDLE);
   assign bus_enable       = in_access;
   assign bus_write_enable = in_access && wr;
   assign bus_address      = !in_access ? '0 :
                             ((state == S_ACCESS_1) ? word_addr + ADDR_WIDTH'(4) : word_addr);
   assign bus_write_data   = (in_access && wr) ? wdata : 32'h0;
   assign bus_write_mask   = !(in_access && wr) ? 4'hf :
                             ((state == S_ACCESS_1) ? ~lane_pair[7:4] : ~lane_pair[3:0]);
   assign resp_valid       = (state == S_RESPOND);
   assign resp_error       = resp_valid && err;
   assign resp_data        = (resp_valid && !err && !wr) ? load_ext : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_load_store_unit : directed self-checking bench for load_store_unit. Rev 1.0
// ----------------------------------------------------------------------------
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid_a, req_valid_b;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [15:0] req_address;
   logic [31:0] req_data;
   logic [31:0] bus_read_data;
   logic        bus_data_ready;

   logic        a_req_ready, a_resp_valid, a_resp_error, a_bus_enable, a_bus_we;
   logic [31:0] a_resp_data, a_bus_wdata;
   logic [15:0] a_bus_address;
   logic [3:0]  a_bus_mask;

   logic        b_req_ready, b_resp_valid, b_resp_error, b_bus_enable, b_bus_we;
   logic [31:0] b_resp_data, b_bus_wdata;
   logic [15:0] b_bus_address;
   logic [3:0]  b_bus_mask;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_WIDTH(16), .MISALIGNED_EN(1'b1), .TIMEOUT_CYCLES(4)) u_a (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid_a), .req_ready(a_req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_address(req_address),
      .req_data(req_data), .resp_valid(a_resp_valid), .resp_data(a_resp_data),
      .resp_error(a_resp_error), .bus_enable(a_bus_enable), .bus_write_enable(a_bus_we),
      .bus_address(a_bus_address), .bus_write_data(a_bus_wdata), .bus_write_mask(a_bus_mask),
      .bus_read_data(bus_read_data), .bus_data_ready(bus_data_ready)
   );

   load_store_unit #(.ADDR_WIDTH(16), .MISALIGNED_EN(1'b0), .TIMEOUT_CYCLES(255)) u_b (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid_b), .req_ready(b_req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_address(req_address),
      .req_data(req_data), .resp_valid(b_resp_valid), .resp_data(b_resp_data),
      .resp_error(b_resp_error), .bus_enable(b_bus_enable), .bus_write_enable(b_bus_we),
      .bus_address(b_bus_address), .bus_write_data(b_bus_wdata), .bus_write_mask(b_bus_mask),
      .bus_read_data(bus_read_data), .bus_data_ready(bus_data_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Present a request at a falling edge; returns one cycle after the accept edge
   task automatic issue(input logic to_b, input logic wr, input logic [1:0] sz,
                        input logic un, input logic [15:0] a, input logic [31:0] d);
      req_write    = wr;
      req_size     = sz;
      req_unsigned = un;
      req_address  = a;
      req_data     = d;
      if (to_b) req_valid_b = 1'b1;
      else      req_valid_a = 1'b1;
      cyc();
      req_valid_a = 1'b0;
      req_valid_b = 1'b0;
   endtask

   task automatic bus_reply(input logic [31:0] rd);
      bus_read_data  = rd;
      bus_data_ready = 1'b1;
      cyc();
      bus_data_ready = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; req_valid_a = 1'b0; req_valid_b = 1'b0; req_write = 1'b0;
      req_size = 2'd0; req_unsigned = 1'b0; req_address = 16'h0; req_data = 32'h0;
      bus_read_data = 32'h0; bus_data_ready = 1'b0;
      cyc(); cyc();

      chk("rst_req_ready",  {31'h0, a_req_ready},  32'h1);
      chk("rst_resp_valid", {31'h0, a_resp_valid}, 32'h0);
      chk("rst_resp_data",  a_resp_data,           32'h0);
      chk("rst_resp_error", {31'h0, a_resp_error}, 32'h0);
      chk("rst_bus_enable", {31'h0, a_bus_enable}, 32'h0);
      chk("rst_bus_we",     {31'h0, a_bus_we},     32'h0);
      chk("rst_bus_addr",   {16'h0, a_bus_address}, 32'h0);
      chk("rst_bus_wdata",  a_bus_wdata,           32'h0);
      chk("rst_bus_mask",   {28'h0, a_bus_mask},   32'hf);
      reset_n = 1'b1;
      cyc();

      // Aligned LW, zero waits
      issue(1'b0, 1'b0, 2'd2, 1'b0, 16'h4000, 32'h0);
      chk("lw_en",        {31'h0, a_bus_enable},  32'h1);
      chk("lw_addr",      {16'h0, a_bus_address}, 32'h4000);
      chk("lw_we",        {31'h0, a_bus_we},      32'h0);
      chk("lw_busy",      {31'h0, a_req_ready},   32'h0);
      chk("lw_no_resp",   {31'h0, a_resp_valid},  32'h0);
      bus_reply(32'hdeadbeef);
      chk("lw_rv",        {31'h0, a_resp_valid},  32'h1);
      chk("lw_data",      a_resp_data,            32'hdeadbeef);
      chk("lw_err",       {31'h0, a_resp_error},  32'h0);
      chk("lw_en_off",    {31'h0, a_bus_enable},  32'h0);
      cyc();
      chk("lw_rv_pulse",  {31'h0, a_resp_valid},  32'h0);
      chk("lw_idle",      {31'h0, a_req_ready},   32'h1);

      // LB / LBU at offset 3
      issue(1'b0, 1'b0, 2'd0, 1'b0, 16'h0003, 32'h0);
      chk("lb_addr",      {16'h0, a_bus_address}, 32'h0);
      bus_reply(32'h80112233);
      chk("lb_data",      a_resp_data,            32'hffffff80);
      cyc();
      issue(1'b0, 1'b0, 2'd0, 1'b1, 16'h0003, 32'h0);
      cyc();
      chk("lbu_wait_en",  {31'h0, a_bus_enable},  32'h1);
      chk("lbu_wait_rv",  {31'h0, a_resp_valid},  32'h0);
      bus_reply(32'h80112233);
      chk("lbu_rv",       {31'h0, a_resp_valid},  32'h1);
      chk("lbu_data",     a_resp_data,            32'h00000080);
      cyc();

      // Halfword loads
      issue(1'b0, 1'b0, 2'd1, 1'b0, 16'h0002, 32'h0);
      bus_reply(32'h80112233);
      chk("lh_data",      a_resp_data,            32'hffff8011);
      cyc();
      issue(1'b0, 1'b0, 2'd1, 1'b1, 16'h0001, 32'h0);
      chk("lhu1_addr",    {16'h0, a_bus_address}, 32'h0);
      bus_reply(32'h80112233);
      chk("lhu1_data",    a_resp_data,            32'h00001122);
      cyc();

      // Stores
      issue(1'b0, 1'b1, 2'd1, 1'b0, 16'h0002, 32'h1234abcd);
      chk("sh_we",        {31'h0, a_bus_we},      32'h1);
      chk("sh_wdata",     a_bus_wdata,            32'habcdabcd);
      chk("sh_mask",      {28'h0, a_bus_mask},    32'h3);
      chk("sh_addr",      {16'h0, a_bus_address}, 32'h0);
      bus_reply(32'h0);
      chk("sh_rv",        {31'h0, a_resp_valid},  32'h1);
      chk("sh_rdata",     a_resp_data,            32'h0);
      cyc();
      issue(1'b0, 1'b1, 2'd0, 1'b0, 16'h0001, 32'h000000a5);
      chk("sb_wdata",     a_bus_wdata,            32'ha5a5a5a5);
      chk("sb_mask",      {28'h0, a_bus_mask},    32'hd);
      bus_reply(32'h0);
      cyc();

      // Misaligned LW split in two with a gap
      issue(1'b0, 1'b0, 2'd2, 1'b0, 16'h0006, 32'h0);
      chk("mlw_addr0",    {16'h0, a_bus_address}, 32'h4);
      chk("mlw_en0",      {31'h0, a_bus_enable},  32'h1);
      bus_reply(32'h44332211);
      chk("mlw_gap_en",   {31'h0, a_bus_enable},  32'h0);
      chk("mlw_gap_rv",   {31'h0, a_resp_valid},  32'h0);
      cyc();
      chk("mlw_en1",      {31'h0, a_bus_enable},  32'h1);
      chk("mlw_addr1",    {16'h0, a_bus_address}, 32'h8);
      bus_reply(32'h88776655);
      chk("mlw_rv",       {31'h0, a_resp_valid},  32'h1);
      chk("mlw_data",     a_resp_data,            32'h66554433);
      chk("mlw_err",      {31'h0, a_resp_error},  32'h0);
      cyc();

      // Misaligned SW with address wrap
      issue(1'b0, 1'b1, 2'd2, 1'b0, 16'hfffe, 32'h11223344);
      chk("msw_addr0",    {16'h0, a_bus_address}, 32'hfffc);
      chk("msw_mask0",    {28'h0, a_bus_mask},    32'h3);
      chk("msw_wdata0",   a_bus_wdata,            32'h33441122);
      bus_reply(32'h0);
      cyc();
      chk("msw_addr1",    {16'h0, a_bus_address}, 32'h0);
      chk("msw_mask1",    {28'h0, a_bus_mask},    32'hc);
      chk("msw_wdata1",   a_bus_wdata,            32'h33441122);
      bus_reply(32'h0);
      chk("msw_rv",       {31'h0, a_resp_valid},  32'h1);
      chk("msw_err",      {31'h0, a_resp_error},  32'h0);
      cyc();

      // Illegal size
      issue(1'b0, 1'b0, 2'd3, 1'b0, 16'h0010, 32'h0);
      chk("ill_rv",       {31'h0, a_resp_valid},  32'h1);
      chk("ill_err",      {31'h0, a_resp_error},  32'h1);
      chk("ill_en",       {31'h0, a_bus_enable},  32'h0);
      cyc();
      chk("ill_idle",     {31'h0, a_req_ready},   32'h1);

      // Misaligned rejected when splitting is disabled
      issue(1'b1, 1'b0, 2'd2, 1'b0, 16'h0006, 32'h0);
      chk("rej_en",       {31'h0, b_bus_enable},  32'h0);
      chk("rej_rv",       {31'h0, b_resp_valid},  32'h1);
      chk("rej_err",      {31'h0, b_resp_error},  32'h1);
      chk("rej_data",     b_resp_data,            32'h0);
      cyc();
      chk("rej_idle",     {31'h0, b_req_ready},   32'h1);

      // Timeout after four cycles without ready
      issue(1'b0, 1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);
      chk("to_en1",       {31'h0, a_bus_enable},  32'h1);
      cyc();
      chk("to_en2",       {31'h0, a_bus_enable},  32'h1);
      cyc();
      chk("to_en3",       {31'h0, a_bus_enable},  32'h1);
      cyc();
      chk("to_en4",       {31'h0, a_bus_enable},  32'h1);
      chk("to_rv4",       {31'h0, a_resp_valid},  32'h0);
      cyc();
      chk("to_rv",        {31'h0, a_resp_valid},  32'h1);
      chk("to_err",       {31'h0, a_resp_error},  32'h1);
      chk("to_en_off",    {31'h0, a_bus_enable},  32'h0);
      cyc();
      chk("to_idle",      {31'h0, a_req_ready},   32'h1);

      // Asynchronous reset during a waiting access
      issue(1'b0, 1'b0, 2'd2, 1'b0, 16'h0020, 32'h0);
      chk("ar_en",        {31'h0, a_bus_enable},  32'h1);
      cyc();
      #2 reset_n = 1'b0;
      #1;
      chk("ar_en_off",    {31'h0, a_bus_enable},  32'h0);
      chk("ar_ready",     {31'h0, a_req_ready},   32'h1);
      chk("ar_addr",      {16'h0, a_bus_address}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      bus_read_data  = 32'hcafef00d;
      bus_data_ready = 1'b1;
      cyc();
      chk("ar_no_rv1",    {31'h0, a_resp_valid},  32'h0);
      bus_data_ready = 1'b0;
      cyc();
      chk("ar_no_rv2",    {31'h0, a_resp_valid},  32'h0);
      chk("ar_idle",      {31'h0, a_req_ready},   32'h1);

      // Normal operation resumes after reset
      issue(1'b0, 1'b0, 2'd2, 1'b0, 16'h0100, 32'h0);
      chk("post_addr",    {16'h0, a_bus_address}, 32'h0100);
      bus_reply(32'h12345678);
      chk("post_data",    a_resp_data,            32'h12345678);
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
